// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetches opcode/operand bytes from synchronous program memory,
//               strobes them to the decoder and updates PC / return stack.
//               Optional macro FETCH_SINGLE_STEP_EN adds a `step` gate after
//               every executed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    output logic [7:0] instruction,
    output logic [7:0] next_byte,
    output logic       exec_valid,
    output logic [7:0] pc,
    input  logic       jump_enable,
    input  logic [7:0] jump_addr,
    input  logic       pc_inc_2,
    input  logic       push_stack,
    input  logic       pop_stack,
    input  logic       halt,
    output logic       halted,
    output logic [4:0] stack_depth,
    output logic       stack_err
);

    localparam int         IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0] C_DEPTH_MAX = 5'(STACK_DEPTH);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_WAIT_OP   = 3'd1,
        ST_WAIT_ARG  = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALTED    = 3'd4,
        ST_STEP_WAIT = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_pc;
    logic [7:0] r_instruction;
    logic [7:0] r_next_byte;
    logic [4:0] r_stack_depth;
    logic       r_stack_err;
    logic [7:0] r_stack [STACK_DEPTH];

    logic       w_multi_byte;
    logic [7:0] w_pc_plus1;
    logic [7:0] w_pc_plus2;
    logic       w_stack_full;
    logic       w_stack_empty;
    logic [4:0] w_depth_m1;
    logic [7:0] w_stack_top;
    logic       w_do_push;
    logic       w_in_exec;

    assign w_multi_byte  = (imem_rdata[7:4] >= 4'h9) && (imem_rdata[7:4] <= 4'hE);
    assign w_pc_plus1    = r_pc + 8'd1;
    assign w_pc_plus2    = r_pc + 8'd2;
    assign w_stack_full  = (r_stack_depth == C_DEPTH_MAX);
    assign w_stack_empty = (r_stack_depth == 5'd0);
    assign w_depth_m1    = r_stack_depth - 5'd1;
    assign w_stack_top   = r_stack[w_depth_m1[IDX_W-1:0]];
    assign w_in_exec     = (r_state == ST_EXEC);
    assign w_do_push     = w_in_exec && !halt && !pop_stack && jump_enable
                           && push_stack && !w_stack_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_addr    = r_pc;
        exec_valid   = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_state_next = ST_WAIT_OP;
            end
            ST_WAIT_OP: begin
                // Operand address is issued while the opcode comes back.
                imem_addr    = w_pc_plus1;
                w_state_next = w_multi_byte ? ST_WAIT_ARG : ST_EXEC;
            end
            ST_WAIT_ARG: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                exec_valid = 1'b1;
                if (halt) begin
                    w_state_next = ST_HALTED;
                end else begin
`ifdef FETCH_SINGLE_STEP_EN
                    w_state_next = ST_STEP_WAIT;
`else
                    w_state_next = ST_FETCH;
`endif
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step) begin
                    w_state_next = ST_FETCH;
                end
            end
`endif
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instruction <= 8'h00;
            r_next_byte   <= 8'h00;
            r_stack_depth <= 5'd0;
            r_stack_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_OP: begin
                    r_instruction <= imem_rdata;
                    if (!w_multi_byte) begin
                        r_next_byte <= 8'h00;
                    end
                end
                ST_WAIT_ARG: begin
                    r_next_byte <= imem_rdata;
                end
                ST_EXEC: begin
                    if (halt) begin
                        r_pc <= r_pc;
                    end else if (pop_stack) begin
                        // Underflowing RET behaves as a NOP but is flagged.
                        if (w_stack_empty) begin
                            r_stack_err <= 1'b1;
                            r_pc        <= w_pc_plus1;
                        end else begin
                            r_stack_depth <= w_depth_m1;
                            r_pc          <= w_stack_top;
                        end
                    end else if (jump_enable) begin
                        if (push_stack) begin
                            if (w_stack_full) begin
                                r_stack_err <= 1'b1;
                            end else begin
                                r_stack_depth <= r_stack_depth + 5'd1;
                            end
                        end
                        r_pc <= jump_addr;
                    end else if (pc_inc_2) begin
                        r_pc <= w_pc_plus2;
                    end else begin
                        r_pc <= w_pc_plus1;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Return-address storage needs no reset: depth alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_stack[r_stack_depth[IDX_W-1:0]] <= w_pc_plus2;
        end
    end

    assign pc          = r_pc;
    assign instruction = r_instruction;
    assign next_byte   = r_next_byte;
    assign stack_depth = r_stack_depth;
    assign stack_err   = r_stack_err;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart of the CPU decode stage.
- Reads opcode and operand bytes from a synchronous program memory, then presents `instruction`/`next_byte` with an `exec_valid` strobe to the decoder.
- Consumes the decoder's sequencing outputs (`jump_enable`, `jump_addr`, `pc_inc_2`, `push_stack`, `pop_stack`, `halt`) to update the PC and the return-address stack.

Parameters:
- STACK_DEPTH, 4, number of 8-bit return-address entries (2..16).
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  8  program memory read address; memory returns data one cycle later.
- imem_rdata  input  8  program memory read data.
- instruction  output  8  latched opcode byte.
- next_byte  output  8  latched operand byte; 8'h00 for single-byte instructions.
- exec_valid  output  1  one-cycle strobe: instruction/next_byte are valid and decoder outputs are sampled; datapath gates reg_we/mem_we with it.
- pc  output  8  address of current instruction.
- jump_enable  input  1  from decoder.
- jump_addr  input  8  from decoder.
- pc_inc_2  input  1  from decoder.
- push_stack  input  1  from decoder (CALL).
- pop_stack  input  1  from decoder (RET).
- halt  input  1  from decoder.
- halted  output  1  high once HALT has executed.
- stack_depth  output  5  current number of stack entries.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, active-high, valid mid-operation):
  - pc=RESET_PC; instruction=8'h00; next_byte=8'h00.
  - exec_valid=0; halted=0; stack_depth=0; stack_err=0.
  - State goes to FETCH. Any in-flight fetch is abandoned.
- imem_addr is combinational from state:
  - FETCH: pc
  - WAIT_OP: pc+1 (8-bit wrap)
  - otherwise: pc
- Multi-byte predecode: opcode imem_rdata[7:4] in 4'b1001..4'b1110.
- FSM states and transitions:
  - FETCH -> WAIT_OP (unconditional).
  - WAIT_OP: instruction <= imem_rdata.
    - Multi-byte: -> WAIT_ARG.
    - Otherwise: next_byte <= 8'h00, -> EXEC.
  - WAIT_ARG: next_byte <= imem_rdata, -> EXEC.
  - EXEC: exec_valid=1. Decoder inputs are sampled and pc is updated this cycle. Next state is HALTED if halt, else FETCH.
  - HALTED: terminal until reset. exec_valid=0, halted=1, pc frozen.
- Latency: single-byte instruction = 3 cycles (FETCH to EXEC inclusive); multi-byte = 4 cycles.
- PC update in EXEC, priority high to low:
  1. halt: pc unchanged.
  2. pop_stack: pc <= top entry; depth-1.
  3. jump_enable: pc <= jump_addr. If push_stack is also high, push pc+2 first.
  4. pc_inc_2: pc <= pc+2.
  5. Otherwise: pc <= pc+1.
- All PC arithmetic is 8-bit modulo 256: 8'hFF+1 = 8'h00; 8'hFF+2 = 8'h01.
- Stack behaviour:
  - LIFO; stack_depth ranges 0..STACK_DEPTH.
  - Push when full: entry discarded, stack_err set, jump still taken.
  - Pop when empty: stack_err set, pc <= pc+1 (RET treated as NOP).
  - stack_err clears only on reset.
- Decoder inputs are ignored outside EXEC.

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- When defined:
  - Extra input `step` (1 bit).
  - EXEC goes to state STEP_WAIT instead of FETCH.
  - STEP_WAIT holds (exec_valid=0) until `step`=1 is sampled, then goes to FETCH.
  - halt still goes to HALTED directly.
- When undefined: no `step` port; EXEC goes to FETCH.

Test Plan:
- Reset, ROM[0]=8'h24 (INC), ROM[1]=8'hF1 (HALT) -> exec_valid pulses at cycle 3 with instruction=8'h24, next_byte=8'h00, then pc=1; second EXEC with halt=1 -> halted=1, pc stays 1.
- ROM[0]=8'h90, ROM[1]=8'h07 (LDI), decoder pc_inc_2=1 -> exec_valid at cycle 4 with next_byte=8'h07; pc=2.
- CALL at 8'h10 to 8'h40 (push_stack, jump_enable, jump_addr=8'h40), then RET at 8'h40 -> pc=8'h40 with stack_depth=1; after RET pc=8'h12 with stack_depth=0.
- STACK_DEPTH=4, 5 nested CALLs -> 5th jump taken, stack_depth=4, stack_err=1; then RET with empty stack -> stack_err stays 1, pc=pc+1.
- pc=8'hFF with multi-byte opcode -> operand read from imem_addr=8'h00; with pc_inc_2, pc becomes 8'h01.
- Assert reset in WAIT_ARG -> all outputs return to reset values immediately; fetch restarts at RESET_PC with no exec_valid glitch.
